// File: rtl/regfile_dump_pkg.sv
// regfile_dump shared types and size defaults.
// REGDUMP_CHECKSUM_EN adds the trailing XOR checksum beat.
package regfile_dump_pkg;

    localparam int DEF_NREGS = 32;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 5;

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1,
        CSUM
    } dump_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1
    } dump_state_t;
`endif

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying dumped register values.
// master drives the beat, slave returns out_ready.
interface regfile_dump_if
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_index;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Sequential register-file sweeper streaming every register as a beat.
// Build with REGDUMP_CHECKSUM_EN for a trailing XOR checksum beat.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             hold,
    output logic             done,
    output logic [AW-1:0]    rd_addr1,
    output logic [AW-1:0]    rd_addr2,
    input  logic [WIDTH-1:0] rd_data1,
    input  logic [WIDTH-1:0] rd_data2,
    regfile_dump_if.master   beat
);

    localparam int KW = AW - 1;
    localparam logic [KW-1:0] KLAST = KW'(NREGS / 2 - 1);

    dump_state_t      state;
    logic [KW-1:0]    k;
    logic [KW-1:0]    kNext;
    logic [WIDTH-1:0] buf1;
    logic             accept;
`ifdef REGDUMP_CHECKSUM_EN
    logic [WIDTH-1:0] csum;
`endif

    assign hold   = busy;
    assign accept = beat.out_valid & beat.out_ready;
    assign kNext  = k + KW'(1);

    // out_data doubles as the first capture buffer (buf0)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            k              <= '0;
            buf1           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            rd_addr1       <= '0;
            rd_addr2       <= '0;
            beat.out_valid <= 1'b0;
            beat.out_data  <= '0;
            beat.out_index <= '0;
            beat.out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        k        <= '0;
                        rd_addr1 <= {KW'(0), 1'b0};
                        rd_addr2 <= {KW'(0), 1'b1};
`ifdef REGDUMP_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                FETCH: begin
                    beat.out_data  <= rd_data1;
                    buf1           <= rd_data2;
                    beat.out_index <= {k, 1'b0};
                    beat.out_last  <= 1'b0;
                    beat.out_valid <= 1'b1;
                    state          <= SEND0;
                end
                SEND0: begin
                    if (accept) begin
                        beat.out_data  <= buf1;
                        beat.out_index <= {k, 1'b1};
`ifdef REGDUMP_CHECKSUM_EN
                        beat.out_last  <= 1'b0;
                        csum           <= csum ^ beat.out_data;
`else
                        beat.out_last  <= (k == KLAST);
`endif
                        state          <= SEND1;
                    end
                end
                SEND1: begin
                    if (accept) begin
                        if (k == KLAST) begin
`ifdef REGDUMP_CHECKSUM_EN
                            beat.out_data  <= csum ^ beat.out_data;
                            beat.out_index <= '0;
                            beat.out_last  <= 1'b1;
                            state          <= CSUM;
`else
                            state          <= IDLE;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            k              <= '0;
                            rd_addr1       <= '0;
                            rd_addr2       <= '0;
                            beat.out_valid <= 1'b0;
                            beat.out_data  <= '0;
                            beat.out_index <= '0;
                            beat.out_last  <= 1'b0;
`endif
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            csum           <= csum ^ beat.out_data;
`endif
                            k              <= kNext;
                            rd_addr1       <= {kNext, 1'b0};
                            rd_addr2       <= {kNext, 1'b1};
                            beat.out_valid <= 1'b0;
                            state          <= FETCH;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        k              <= '0;
                        rd_addr1       <= '0;
                        rd_addr2       <= '0;
                        beat.out_valid <= 1'b0;
                        beat.out_data  <= '0;
                        beat.out_index <= '0;
                        beat.out_last  <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: sweeps, stalls, restart, async reset.
// Honours REGDUMP_CHECKSUM_EN to expect the trailing checksum beat.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int N = DEF_NREGS;
    localparam int W = DEF_WIDTH;
    localparam int A = DEF_AW;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int EXP_CYC = 49;
`else
    localparam int EXP_CYC = 48;
`endif

    typedef struct packed {
        logic         last;
        logic [A-1:0] idx;
        logic [W-1:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         busy, hold, done;
    logic [A-1:0] rdAddr1, rdAddr2;
    logic [W-1:0] rdData1, rdData2;
    logic [W-1:0] rf [N];

    beat_t expQ[$];
    int    vectors = 0;
    int    miscompares = 0;
    beat_t prevB;
    logic  prevHeld;

    regfile_dump_if #(.WIDTH(W), .AW(A)) beat ();

    regfile_dump dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .hold     (hold),
        .done     (done),
        .rd_addr1 (rdAddr1),
        .rd_addr2 (rdAddr2),
        .rd_data1 (rdData1),
        .rd_data2 (rdData2),
        .beat     (beat)
    );

    assign rdData1 = rf[rdAddr1];
    assign rdData2 = rf[rdAddr2];

    always #5 clk = ~clk;

    // beat monitor: stall stability and in-order scoreboard pop
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {beat.out_last, beat.out_index, beat.out_data};
        if (!rst) begin
            prevHeld <= 1'b0;
        end else begin
            if (prevHeld) begin
                vectors++;
                if (!beat.out_valid || cur !== prevB) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%0b %h want v=1 %h",
                             beat.out_valid, cur, prevB);
                end
            end
            if (beat.out_valid && beat.out_ready) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: got %h want none", cur);
                end else begin
                    e = expQ.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL beat: got last=%0b idx=%0d data=%h want last=%0b idx=%0d data=%h",
                                 cur.last, cur.idx, cur.data, e.last, e.idx, e.data);
                    end
                end
            end
            prevHeld <= beat.out_valid && !beat.out_ready;
            prevB    <= cur;
        end
    end

    function automatic void push_sweep(input int count);
        logic [W-1:0] x;
        beat_t b;
        x = '0;
        for (int i = 0; i < count; i++) begin
            b.data = rf[i];
            b.idx  = A'(i);
            b.last = 1'b0;
`ifndef REGDUMP_CHECKSUM_EN
            b.last = (i == N - 1);
`endif
            expQ.push_back(b);
            x ^= rf[i];
        end
`ifdef REGDUMP_CHECKSUM_EN
        if (count == N) begin
            b.data = x;
            b.idx  = '0;
            b.last = 1'b1;
            expQ.push_back(b);
        end
`endif
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
    endtask

    // runs one sweep to idle, measuring busy cycles, dones and hold
    task automatic wait_idle(input bit rnd, input int restartAt,
                             output int cyc, output int dn,
                             output int holdErr, output int fv,
                             output bit timeout);
        bit fin;
        cyc = 0; dn = 0; holdErr = 0; fv = 0;
        timeout = 1'b1;
        fin = 1'b0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            @(posedge clk);
            #1;
            beat.out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            start = (restartAt > 0 && cyc == restartAt);
            @(negedge clk);
            if (hold !== busy) holdErr++;
            if (done) dn++;
            if (busy) begin
                cyc++;
                if (beat.out_valid && fv == 0) fv = cyc;
            end else if (cyc > 0) begin
                fin = 1'b1;
                timeout = 1'b0;
            end
        end
        @(negedge clk);
        if (done) dn++;
        beat.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, hold, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got %b want 000", {busy, hold, done});
        end
        vectors++;
        if ({beat.out_valid, beat.out_last} !== 2'b00 ||
            beat.out_data !== '0 || beat.out_index !== '0) begin
            miscompares++;
            $display("FAIL reset_beat: got v=%0b l=%0b d=%h i=%0d want 0",
                     beat.out_valid, beat.out_last, beat.out_data, beat.out_index);
        end
        vectors++;
        if (rdAddr1 !== '0 || rdAddr2 !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: got %0d/%0d want 0/0", rdAddr1, rdAddr2);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_sweep(input string nm, input bit exact,
                               input int cyc, input int dn, input int he,
                               input bit to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s_timeout: got timeout want idle", nm);
        end
        vectors++;
        if (exact ? (cyc != EXP_CYC) : (cyc < EXP_CYC)) begin
            miscompares++;
            $display("FAIL %s_cycles: got %0d want %0d", nm, cyc, EXP_CYC);
        end
        vectors++;
        if (dn != 1) begin
            miscompares++;
            $display("FAIL %s_done: got %0d pulses want 1", nm, dn);
        end
        vectors++;
        if (he != 0) begin
            miscompares++;
            $display("FAIL %s_hold: got %0d cycles hold!=busy want 0", nm, he);
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL %s_beats: got %0d unseen want 0", nm, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_sweep();
        int cyc, dn, he, fv;
        bit to;
        for (int i = 0; i < N; i++) rf[i] = 32'hA5A50000 + W'(i);
        push_sweep(N);
        pulse_start();
        wait_idle(1'b0, 0, cyc, dn, he, fv, to);
        check_sweep("sweep", 1'b1, cyc, dn, he, to);
        vectors++;
        if (fv != 2) begin
            miscompares++;
            $display("FAIL first_valid: got cycle %0d want 2", fv);
        end
    endtask

    task automatic test_random_ready();
        int cyc, dn, he, fv;
        bit to;
        for (int i = 0; i < N; i++) rf[i] = $urandom;
        push_sweep(N);
        pulse_start();
        wait_idle(1'b1, 0, cyc, dn, he, fv, to);
        check_sweep("rnd_ready", 1'b0, cyc, dn, he, to);
    endtask

    task automatic test_start_ignored();
        int cyc, dn, he, fv;
        bit to;
        for (int i = 0; i < N; i++) rf[i] = 32'h5A5A0000 ^ W'(i * 7);
        push_sweep(N);
        pulse_start();
        wait_idle(1'b0, 10, cyc, dn, he, fv, to);
        check_sweep("restart", 1'b1, cyc, dn, he, to);
    endtask

    task automatic test_async_reset();
        int cyc, dn, he, fv, dseen;
        bit to, found;
        for (int i = 0; i < N; i++) rf[i] = 32'hA5A50000 + W'(i);
        push_sweep(10);
        beat.out_ready = 1'b1;
        pulse_start();
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (beat.out_valid && beat.out_index == A'(9)) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL arst_reach: got no index 9 beat want one");
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({beat.out_valid, busy, hold, done, beat.out_last} !== 5'b0 ||
            beat.out_data !== '0 || beat.out_index !== '0 ||
            rdAddr1 !== '0 || rdAddr2 !== '0) begin
            miscompares++;
            $display("FAIL arst_outputs: got v=%0b b=%0b h=%0b d=%0b want 0",
                     beat.out_valid, busy, hold, done);
        end
        dseen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dseen++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        vectors++;
        if (dseen != 0) begin
            miscompares++;
            $display("FAIL arst_nodone: got %0d done/busy cycles want 0", dseen);
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL arst_partial: got %0d unseen want 0", expQ.size());
        end
        expQ.delete();
        push_sweep(N);
        pulse_start();
        wait_idle(1'b0, 0, cyc, dn, he, fv, to);
        check_sweep("arst_fresh", 1'b1, cyc, dn, he, to);
    endtask

    initial begin
        beat.out_ready = 1'b1;
        for (int i = 0; i < N; i++) rf[i] = '0;
        test_reset();
        test_sweep();
        test_random_ready();
        test_start_ignored();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
